// File: rtl/increment_arbiter_if.sv
// Requester-side bundle for increment_arbiter: requests, operands, enables and registered result.
// Lock exists only when INC_ARB_LOCK_EN is defined.
interface increment_arbiter_if #(
    parameter int width = 16,
    parameter int NReq  = 4
);
    logic [NReq-1:0]       Req;
    logic [NReq*width-1:0] Data;
    logic [NReq-1:0]       IncEn;
`ifdef INC_ARB_LOCK_EN
    logic [NReq-1:0]       Lock;
`endif
    logic [NReq-1:0]       Gnt;
    logic [width-1:0]      Out;
    logic                  Carry;
    logic                  Valid;

`ifdef INC_ARB_LOCK_EN
    modport master (output Req, Data, IncEn, Lock, input Gnt, Out, Carry, Valid);
    modport slave  (input Req, Data, IncEn, Lock, output Gnt, Out, Carry, Valid);
`else
    modport master (output Req, Data, IncEn, input Gnt, Out, Carry, Valid);
    modport slave  (input Req, Data, IncEn, output Gnt, Out, Carry, Valid);
`endif
endinterface

// File: rtl/increment_arbiter.sv
// Round-robin arbiter sharing one incrementer among NReq requesters; optional lock via INC_ARB_LOCK_EN.
// Latency: 1 cycle from sampled Req to registered Gnt/Out/Carry/Valid.
// Backpressure: none; losers are not queued and must hold Req to be reconsidered next cycle.
module Increment #(
    parameter int width = 16
) (
    input  logic [width-1:0] In,
    input  logic             Sw,
    output logic [width-1:0] Out,
    output logic             Carry
);
    assign {Carry, Out} = {1'b0, In} + {{width{1'b0}}, Sw};
endmodule

module increment_arbiter #(
    parameter int width = 16,
    parameter int NReq  = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    increment_arbiter_if.slave bus
);
    localparam int              PW   = (NReq > 1) ? $clog2(NReq) : 1;
    localparam logic [PW-1:0]   LAST = PW'(NReq - 1);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NReq-1:0]  gnt_q, gnt_d;
    logic [width-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    logic [PW-1:0]    win_idx;
    logic             win_vld;
    logic [PW-1:0]    ptr_adv;
    logic             lock_hit;
    logic [width-1:0] inc_in, inc_out;
    logic             inc_sw, inc_carry;
    logic [width-1:0] data_a [NReq];

    for (genvar i = 0; i < NReq; i++) begin : g_unpack
        assign data_a[i] = bus.Data[i*width +: width];
    end

    // Scan starts at ptr_q and wraps; first requesting index wins.
    always_comb begin
        int sum;
        win_vld = 1'b0;
        win_idx = '0;
        sum     = 0;
        for (int k = 0; k < NReq; k++) begin
            sum = int'(ptr_q) + k;
            if (sum >= NReq) sum = sum - NReq;
            if (!win_vld && bus.Req[PW'(sum)]) begin
                win_vld = 1'b1;
                win_idx = PW'(sum);
            end
        end
    end

    assign inc_in  = data_a[win_idx];
    assign inc_sw  = bus.IncEn[win_idx];
    assign ptr_adv = (win_idx == LAST) ? '0 : win_idx + 1'b1;

`ifdef INC_ARB_LOCK_EN
    assign lock_hit = bus.Lock[win_idx];
`else
    assign lock_hit = 1'b0;
`endif

    Increment #(.width(width)) u_inc (
        .In    (inc_in),
        .Sw    (inc_sw),
        .Out   (inc_out),
        .Carry (inc_carry)
    );

    always_comb begin
        gnt_d   = '0;
        out_d   = out_q;
        carry_d = carry_q;
        valid_d = 1'b0;
        ptr_d   = ptr_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            out_d          = inc_out;
            carry_d        = inc_carry;
            valid_d        = 1'b1;
            ptr_d          = lock_hit ? win_idx : ptr_adv;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign bus.Gnt   = gnt_q;
    assign bus.Out   = out_q;
    assign bus.Carry = carry_q;
    assign bus.Valid = valid_q;
endmodule

// File: tb/tb_increment_arbiter.sv
// Directed bench for increment_arbiter with a scoreboard of hand-derived expected outputs.
// The lock sequence is exercised only when INC_ARB_LOCK_EN is defined.
module tb_increment_arbiter;
    typedef struct packed {
        logic [3:0]  gnt;
        logic [15:0] out;
        logic        carry;
        logic        valid;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t  sb[$];
    string tag_q[$];

    increment_arbiter_if #(.width(16), .NReq(4)) bus ();

    increment_arbiter #(.width(16), .NReq(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string tag, input logic [3:0] gnt, input logic [15:0] out,
                            input logic carry, input logic valid);
        exp_t e;
        e.gnt = gnt; e.out = out; e.carry = carry; e.valid = valid;
        sb.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_pop();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty got 0 entries exp at least 1");
            return;
        end
        e = sb.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (bus.Gnt === e.gnt) else begin
            errors++; $error("FAIL %s gnt got %b exp %b", t, bus.Gnt, e.gnt);
        end
        checks++;
        assert (bus.Out === e.out) else begin
            errors++; $error("FAIL %s out got %h exp %h", t, bus.Out, e.out);
        end
        checks++;
        assert (bus.Carry === e.carry) else begin
            errors++; $error("FAIL %s carry got %b exp %b", t, bus.Carry, e.carry);
        end
        checks++;
        assert (bus.Valid === e.valid) else begin
            errors++; $error("FAIL %s valid got %b exp %b", t, bus.Valid, e.valid);
        end
    endtask

    // Drive at a falling edge, expect the result after the next rising edge.
    task automatic cyc(input string tag, input logic [3:0] req, input logic [3:0] gnt,
                       input logic [15:0] out, input logic carry, input logic valid);
        bus.Req = req;
        push_exp(tag, gnt, out, carry, valid);
        @(negedge Clk);
        check_pop();
    endtask

    task automatic set_data(input int i, input logic [15:0] d, input logic en);
        bus.Data[i*16 +: 16] = d;
        bus.IncEn[i] = en;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        bus.Req = '0;
        @(negedge Clk);
        @(negedge Clk);
        push_exp("in_reset", 4'b0000, 16'h0000, 1'b0, 1'b0);
        check_pop();
        Rst_n = 1'b1;
    endtask

    logic [15:0] rr_out [4];

    initial begin
        bus.Req   = '0;
        bus.Data  = '0;
        bus.IncEn = '0;
`ifdef INC_ARB_LOCK_EN
        bus.Lock  = '0;
`endif
        Rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < 3; i++) cyc("idle", 4'b0000, 4'b0000, 16'h0000, 1'b0, 1'b0);

        set_data(0, 16'h00FF, 1'b1);
        cyc("single_r0", 4'b0001, 4'b0001, 16'h0100, 1'b0, 1'b1);
        cyc("single_hold", 4'b0000, 4'b0000, 16'h0100, 1'b0, 1'b0);

        set_data(2, 16'hFFFF, 1'b1);
        cyc("ovf_inc", 4'b0100, 4'b0100, 16'h0000, 1'b1, 1'b1);
        set_data(2, 16'hFFFF, 1'b0);
        cyc("ovf_pass", 4'b0100, 4'b0100, 16'hFFFF, 1'b0, 1'b1);
        cyc("ovf_hold", 4'b0000, 4'b0000, 16'hFFFF, 1'b0, 1'b0);

        do_reset();
        set_data(0, 16'h1000, 1'b1);
        set_data(1, 16'h2000, 1'b0);
        set_data(2, 16'h3000, 1'b1);
        set_data(3, 16'h4000, 1'b0);
        rr_out[0] = 16'h1001; rr_out[1] = 16'h2000;
        rr_out[2] = 16'h3001; rr_out[3] = 16'h4000;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] g;
            g = 4'b0001 << (i % 4);
            cyc("rr_all", 4'b1111, g, rr_out[i % 4], 1'b0, 1'b1);
        end

        cyc("pre_rst", 4'b1010, 4'b0010, 16'h2000, 1'b0, 1'b1);
        #2 Rst_n = 1'b0;
        #1;
        push_exp("async_clear", 4'b0000, 16'h0000, 1'b0, 1'b0);
        check_pop();
        @(negedge Clk);
        push_exp("held_reset", 4'b0000, 16'h0000, 1'b0, 1'b0);
        check_pop();
        Rst_n = 1'b1;
        cyc("post_rst0", 4'b1010, 4'b0010, 16'h2000, 1'b0, 1'b1);
        cyc("post_rst1", 4'b1010, 4'b1000, 16'h4000, 1'b0, 1'b1);
        cyc("post_rst2", 4'b1010, 4'b0010, 16'h2000, 1'b0, 1'b1);

`ifdef INC_ARB_LOCK_EN
        do_reset();
        bus.Lock = 4'b0001;
        cyc("lock0", 4'b0011, 4'b0001, 16'h1001, 1'b0, 1'b1);
        cyc("lock1", 4'b0011, 4'b0001, 16'h1001, 1'b0, 1'b1);
        bus.Lock = 4'b0000;
        cyc("lock2", 4'b0011, 4'b0001, 16'h1001, 1'b0, 1'b1);
        cyc("unlock", 4'b0011, 4'b0010, 16'h2000, 1'b0, 1'b1);
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover got %0d entries exp 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
